unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data RAM between the IF-stage fetch port and the MEM-stage load/store port.
- Arbitrates requests, sequences each RAM access over a fixed latency, and returns registered data with a one-cycle valid pulse.
- Drives stall requests into hazard_unit so that a losing or waiting stage holds.
- Sits between if_stage/mem_stage and the shared RAM macro.

---
 rtl/unified_mem_arbiter_pkg.sv | 26 ++
 rtl/unified_mem_arbiter_pick.sv | 48 ++++
 rtl/unified_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Contents:
//   D_WIDTH  - default address/data width.
//   CNT_W    - width of the latency and starvation counters.
//   state_t  - access sequencer states.
//             ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3.
//   owner_t  - which port owns the current access.
//             OWN_IF=0, OWN_MEM=1.
package unified_mem_arbiter_pkg;

    localparam int D_WIDTH = 32;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the unified memory arbiter.
// MEM has fixed priority over IF. When UNIFIED_MEM_STARVE_GUARD_EN is
// defined, a waiting fetch wins once the starvation count has reached
// STARVE_MAX. Without the macro there is no count input and strict MEM
// priority applies.
// Ports:
//   if_req       in   fetch request
//   mem_req      in   load/store request
//   starve_cnt   in   consecutive MEM grants while IF waited (guard only)
//   grant_valid  out  some request is present
//   grant_owner  out  winning port
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
#(
    parameter logic [CNT_W-1:0] STARVE_MAX = 4'd4
)
`endif
(
    input  logic             if_req,
    input  logic             mem_req,
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_valid,
    output owner_t           grant_owner
);

    // Winner select: MEM first, except when the guard hands a turn to IF.
    always_comb begin
        grant_valid = if_req | mem_req;
        grant_owner = OWN_IF;
        if (mem_req) begin
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
            if (if_req && (starve_cnt == STARVE_MAX)) begin
                grant_owner = OWN_IF;
            end else begin
                grant_owner = OWN_MEM;
            end
`else
            grant_owner = OWN_MEM;
`endif
        end else begin
            grant_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported instruction/data RAM between
// the IF-stage fetch port and the MEM-stage load/store port. Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE, then the owner gets a
// one-cycle valid pulse. Read data is held per port until that port's next read.
// Optional feature macro: UNIFIED_MEM_STARVE_GUARD_EN (fetch starvation guard).
// Ports:
//   clk, rst_n                   clock; asynchronous reset, active-high
//   i_IfReq/i_IfAddr             fetch request and address
//   o_IfValid/o_IfRData          fetch valid pulse and instruction
//   i_MemReq/i_MemWE             load/store request, 1 = store
//   i_MemAddr/i_MemWData         data address and store data
//   o_MemValid/o_MemRData        load/store completion pulse and load data
//   o_StallIF/o_StallMEM         hold requests to hazard_unit
//   o_RamEn/o_RamWE              RAM strobe and write enable
//   o_RamAddr/o_RamWData         RAM address and write data
//   i_RamRData                   RAM read data
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int D_WIDTH = unified_mem_arbiter_pkg::D_WIDTH,
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
    parameter logic [CNT_W-1:0] STARVE_MAX = 4'd4,
`endif
    parameter int MEM_LAT = 2
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_IfReq,
    input  logic [D_WIDTH-1:0] i_IfAddr,
    output logic               o_IfValid,
    output logic [D_WIDTH-1:0] o_IfRData,
    input  logic               i_MemReq,
    input  logic               i_MemWE,
    input  logic [D_WIDTH-1:0] i_MemAddr,
    input  logic [D_WIDTH-1:0] i_MemWData,
    output logic               o_MemValid,
    output logic [D_WIDTH-1:0] o_MemRData,
    output logic               o_StallIF,
    output logic               o_StallMEM,
    output logic               o_RamEn,
    output logic               o_RamWE,
    output logic [D_WIDTH-1:0] o_RamAddr,
    output logic [D_WIDTH-1:0] o_RamWData,
    input  logic [D_WIDTH-1:0] i_RamRData
);

    localparam logic [CNT_W-1:0] LAT = MEM_LAT[CNT_W-1:0];

    state_t             state_r;
    state_t             state_s;
    owner_t             owner_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [D_WIDTH-1:0] addr_r;
    logic               we_r;
    logic [D_WIDTH-1:0] wdata_r;
    logic [D_WIDTH-1:0] if_rdata_r;
    logic [D_WIDTH-1:0] mem_rdata_r;
    logic               grant_valid_s;
    owner_t             grant_owner_s;
    logic               arb_s;
    logic               sample_s;

    // Arbitration happens only in IDLE; the winner is latched for the access.
    assign arb_s    = (state_r == ST_IDLE) && grant_valid_s;
    // The RAM data is valid in the last WAIT cycle.
    assign sample_s = (state_r == ST_WAIT) && (cnt_r <= 4'd1);

`ifdef UNIFIED_MEM_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_r;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .if_req      (i_IfReq),
        .mem_req     (i_MemReq),
        .starve_cnt  (starve_r),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // Starvation count: MEM grants made while a fetch was waiting, saturating.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            starve_r <= 4'd0;
        end else if (arb_s) begin
            if (grant_owner_s == OWN_IF) begin
                starve_r <= 4'd0;
            end else if (i_IfReq && (starve_r != 4'hF)) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= starve_r;
            end
        end else begin
            starve_r <= starve_r;
        end
    end
`else
    mem_arb_pick u_pick (
        .if_req      (i_IfReq),
        .mem_req     (i_MemReq),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );
`endif

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Latch the winning request; the RAM is driven from these during ISSUE.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            owner_r <= OWN_IF;
            addr_r  <= {D_WIDTH{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {D_WIDTH{1'b0}};
        end else if (arb_s) begin
            owner_r <= grant_owner_s;
            if (grant_owner_s == OWN_MEM) begin
                addr_r  <= i_MemAddr;
                we_r    <= i_MemWE;
                wdata_r <= i_MemWData;
            end else begin
                addr_r  <= i_IfAddr;
                we_r    <= 1'b0;
                wdata_r <= {D_WIDTH{1'b0}};
            end
        end else begin
            owner_r <= owner_r;
            addr_r  <= addr_r;
            we_r    <= we_r;
            wdata_r <= wdata_r;
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_r <= 4'd0;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= LAT;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Per-port read data; stores leave both registers untouched.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            if_rdata_r  <= {D_WIDTH{1'b0}};
            mem_rdata_r <= {D_WIDTH{1'b0}};
        end else if (sample_s && !we_r) begin
            if (owner_r == OWN_MEM) begin
                mem_rdata_r <= i_RamRData;
            end else begin
                if_rdata_r  <= i_RamRData;
            end
        end else begin
            if_rdata_r  <= if_rdata_r;
            mem_rdata_r <= mem_rdata_r;
        end
    end

    // RAM buses are driven only during ISSUE so they read as zero otherwise.
    assign o_RamEn    = (state_r == ST_ISSUE);
    assign o_RamWE    = o_RamEn & we_r;
    assign o_RamAddr  = o_RamEn ? addr_r  : {D_WIDTH{1'b0}};
    assign o_RamWData = o_RamEn ? wdata_r : {D_WIDTH{1'b0}};

    assign o_IfValid  = (state_r == ST_DONE) && (owner_r == OWN_IF);
    assign o_MemValid = (state_r == ST_DONE) && (owner_r == OWN_MEM);
    assign o_IfRData  = if_rdata_r;
    assign o_MemRData = mem_rdata_r;

    assign o_StallIF  = i_IfReq  & ~o_IfValid;
    assign o_StallMEM = i_MemReq & ~o_MemValid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (MEM_LAT=2). Cycle c0 is the cycle
// a request is first presented in IDLE; ISSUE is c1, valid pulse is c4.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_IfReq, i_MemReq, i_MemWE;
    logic [31:0] i_IfAddr, i_MemAddr, i_MemWData, i_RamRData;
    logic        o_IfValid, o_MemValid, o_StallIF, o_StallMEM, o_RamEn, o_RamWE;
    logic [31:0] o_IfRData, o_MemRData, o_RamAddr, o_RamWData;

    int total = 0;
    int bad   = 0;

    unified_mem_arbiter #(.D_WIDTH(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_IfReq(i_IfReq), .i_IfAddr(i_IfAddr),
        .o_IfValid(o_IfValid), .o_IfRData(o_IfRData),
        .i_MemReq(i_MemReq), .i_MemWE(i_MemWE),
        .i_MemAddr(i_MemAddr), .i_MemWData(i_MemWData),
        .o_MemValid(o_MemValid), .o_MemRData(o_MemRData),
        .o_StallIF(o_StallIF), .o_StallMEM(o_StallMEM),
        .o_RamEn(o_RamEn), .o_RamWE(o_RamWE),
        .o_RamAddr(o_RamAddr), .o_RamWData(o_RamWData),
        .i_RamRData(i_RamRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifvalid"},  {31'd0, o_IfValid},  32'd0);
        check({tag, "_memvalid"}, {31'd0, o_MemValid}, 32'd0);
        check({tag, "_ifrdata"},  o_IfRData,  32'd0);
        check({tag, "_memrdata"}, o_MemRData, 32'd0);
        check({tag, "_stalls"},   {30'd0, o_StallIF, o_StallMEM}, 32'd0);
        check({tag, "_ramen_we"}, {30'd0, o_RamEn, o_RamWE}, 32'd0);
        check({tag, "_ramaddr"},  o_RamAddr,  32'd0);
        check({tag, "_ramwdata"}, o_RamWData, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic exp_mem [6];

        rst_n = 1'b1;
        i_IfReq = 1'b0; i_MemReq = 1'b0; i_MemWE = 1'b0;
        i_IfAddr = 32'd0; i_MemAddr = 32'd0; i_MemWData = 32'd0; i_RamRData = 32'd0;
        #2;
        check_all_zero("reset");
        cyc(); cyc();
        rst_n = 1'b0;

        // Single fetch
        i_IfReq = 1'b1; i_IfAddr = 32'h10; i_RamRData = 32'hE3A01005;
        #1;
        check("f_c0_stall", {31'd0, o_StallIF}, 32'd1);
        check("f_c0_ramen", {31'd0, o_RamEn}, 32'd0);
        cyc(); #1;
        check("f_c1_ramen", {31'd0, o_RamEn}, 32'd1);
        check("f_c1_addr", o_RamAddr, 32'h10);
        check("f_c1_we", {31'd0, o_RamWE}, 32'd0);
        check("f_c1_stall", {31'd0, o_StallIF}, 32'd1);
        cyc(); #1;
        check("f_c2_ramen", {31'd0, o_RamEn}, 32'd0);
        check("f_c2_stall", {31'd0, o_StallIF}, 32'd1);
        cyc(); #1;
        check("f_c3_valid", {31'd0, o_IfValid}, 32'd0);
        check("f_c3_stall", {31'd0, o_StallIF}, 32'd1);
        cyc(); #1;
        check("f_c4_valid", {31'd0, o_IfValid}, 32'd1);
        check("f_c4_data", o_IfRData, 32'hE3A01005);
        check("f_c4_stall", {31'd0, o_StallIF}, 32'd0);
        i_IfReq = 1'b0;
        cyc(); #1;
        check("f_c5_valid", {31'd0, o_IfValid}, 32'd0);
        check("f_c5_hold", o_IfRData, 32'hE3A01005);
        check("f_c5_ramen", {31'd0, o_RamEn}, 32'd0);

        // Store
        i_MemReq = 1'b1; i_MemWE = 1'b1; i_MemAddr = 32'h200;
        i_MemWData = 32'hDEADBEEF; i_RamRData = 32'h11111111;
        #1;
        check("s_c0_stall", {31'd0, o_StallMEM}, 32'd1);
        cyc(); #1;
        check("s_c1_en_we", {30'd0, o_RamEn, o_RamWE}, 32'd3);
        check("s_c1_addr", o_RamAddr, 32'h200);
        check("s_c1_wdata", o_RamWData, 32'hDEADBEEF);
        cyc(); #1;
        check("s_c2_en", {31'd0, o_RamEn}, 32'd0);
        cyc(); #1;
        check("s_c3_valid", {31'd0, o_MemValid}, 32'd0);
        cyc(); #1;
        check("s_c4_valid", {31'd0, o_MemValid}, 32'd1);
        check("s_c4_rdata", o_MemRData, 32'd0);
        check("s_c4_stall", {31'd0, o_StallMEM}, 32'd0);
        i_MemReq = 1'b0; i_MemWE = 1'b0;
        cyc(); #1;
        check("s_c5_valid", {31'd0, o_MemValid}, 32'd0);

        // Load on the MEM port
        i_MemReq = 1'b1; i_MemAddr = 32'h300; i_RamRData = 32'hCAFEF00D;
        cyc(); #1;
        check("l_c1_en_we", {30'd0, o_RamEn, o_RamWE}, 32'd2);
        check("l_c1_addr", o_RamAddr, 32'h300);
        cyc(); cyc(); cyc(); #1;
        check("l_c4_valid", {31'd0, o_MemValid}, 32'd1);
        check("l_c4_data", o_MemRData, 32'hCAFEF00D);
        check("l_c4_ifdata", o_IfRData, 32'hE3A01005);
        i_MemReq = 1'b0;
        cyc();

        // Contention: MEM first, IF issued two cycles after MEM DONE
        i_MemReq = 1'b1; i_MemAddr = 32'h40; i_IfReq = 1'b1; i_IfAddr = 32'h80;
        i_RamRData = 32'h12345678;
        cyc(); #1;
        check("c_c1_addr", o_RamAddr, 32'h40);
        check("c_c1_en", {31'd0, o_RamEn}, 32'd1);
        cyc(); cyc(); cyc(); #1;
        check("c_c4_valids", {30'd0, o_IfValid, o_MemValid}, 32'd1);
        check("c_c4_memdata", o_MemRData, 32'h12345678);
        check("c_c4_stallif", {31'd0, o_StallIF}, 32'd1);
        i_MemReq = 1'b0; i_RamRData = 32'h87654321;
        cyc(); #1;
        check("c_c5_en", {31'd0, o_RamEn}, 32'd0);
        cyc(); #1;
        check("c_c6_en", {31'd0, o_RamEn}, 32'd1);
        check("c_c6_addr", o_RamAddr, 32'h80);
        cyc(); cyc(); cyc(); #1;
        check("c_c9_valids", {30'd0, o_IfValid, o_MemValid}, 32'd2);
        check("c_c9_ifdata", o_IfRData, 32'h87654321);
        check("c_c9_memhold", o_MemRData, 32'h12345678);
        i_IfReq = 1'b0;
        cyc();

        // Dropped fetch request during WAIT
        i_IfReq = 1'b1; i_IfAddr = 32'h90; i_RamRData = 32'hA5A5A5A5;
        cyc(); #1;
        check("d_c1_addr", o_RamAddr, 32'h90);
        cyc();
        i_IfReq = 1'b0;
        #1;
        check("d_c2_stall", {31'd0, o_StallIF}, 32'd0);
        cyc(); cyc(); #1;
        check("d_c4_valid", {31'd0, o_IfValid}, 32'd1);
        check("d_c4_data", o_IfRData, 32'hA5A5A5A5);
        cyc(); #1;
        check("d_c5_en", {31'd0, o_RamEn}, 32'd0);
        cyc(); #1;
        check("d_c6_en", {31'd0, o_RamEn}, 32'd0);

        // Reset asserted in WAIT
        i_MemReq = 1'b1; i_MemAddr = 32'h50; i_RamRData = 32'h0F0F0F0F;
        cyc(); #1;
        check("r_c1_en", {31'd0, o_RamEn}, 32'd1);
        cyc();
        rst_n = 1'b1; i_MemReq = 1'b0;
        #1;
        check_all_zero("midrst");
        cyc(); cyc();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("r_post_quiet", {29'd0, o_MemValid, o_IfValid, o_RamEn}, 32'd0);
            cyc();
        end

        // Starvation: both requests held continuously
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        i_MemReq = 1'b1; i_MemWE = 1'b0; i_MemAddr = 32'h100;
        i_IfReq = 1'b1; i_IfAddr = 32'h104; i_RamRData = 32'h0;
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            check("st_en", {31'd0, o_RamEn}, 32'd1);
            check("st_addr", o_RamAddr, exp_mem[k] ? 32'h100 : 32'h104);
            cyc(); cyc(); cyc(); #1;
            check("st_valid", {30'd0, o_IfValid, o_MemValid},
                  exp_mem[k] ? 32'd1 : 32'd2);
            cyc();
        end
        i_MemReq = 1'b0; i_IfReq = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
